// File: rtl/dds_multi_ch.sv
// dds_multi_ch: parametrised multi-channel DDS waveform core.
// Each channel has a frequency tuning word, phase offset, amplitude and
// waveform mode. Commands write per-channel shadow registers. APPLY copies
// every shadow set to the active registers on the same edge.
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   cmd_valid/cmd_ready command handshake (ready drops one cycle after APPLY)
//   cmd_ch, cmd_reg     target channel, register (0 FTW,1 POFF,2 AMP,3 MODE,4 APPLY)
//   cmd_data            LSB-aligned write data
//   dac_data            packed unsigned DAC codes, channel n at [n*DAC_W +: DAC_W]
//   dac_wr              dac_data valid, high from the 3rd edge after reset release
module dds_multi_ch #(
  parameter int NCH     = 2,
  parameter int ACC_W   = 32,
  parameter int PHASE_W = 10,
  parameter int DAC_W   = 14,
  parameter int AMP_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [2:0]           cmd_ch,
  input  logic [2:0]           cmd_reg,
  input  logic [ACC_W-1:0]     cmd_data,
  output logic [NCH*DAC_W-1:0] dac_data,
  output logic                 dac_wr
);

  localparam logic [2:0] REG_FTW   = 3'd0;
  localparam logic [2:0] REG_POFF  = 3'd1;
  localparam logic [2:0] REG_AMP   = 3'd2;
  localparam logic [2:0] REG_MODE  = 3'd3;
  localparam logic [2:0] REG_APPLY = 3'd4;
  localparam int         PROD_W    = DAC_W + AMP_W;

  // shadow and active configuration
  logic [ACC_W-1:0]   r_sh_ftw  [NCH];
  logic [PHASE_W-1:0] r_sh_poff [NCH];
  logic [AMP_W-1:0]   r_sh_amp  [NCH];
  logic [2:0]         r_sh_mode [NCH];
  logic [ACC_W-1:0]   r_ftw     [NCH];
  logic [PHASE_W-1:0] r_poff    [NCH];
  logic [AMP_W-1:0]   r_amp     [NCH];
  logic [2:0]         r_mode    [NCH];

  // pipeline: S1 accumulator plus the config that produced it, S2 waveform, S3 scaled
  logic [ACC_W-1:0]   r_acc     [NCH];
  logic [PHASE_W-1:0] r_s1_poff [NCH];
  logic [1:0]         r_s1_wave [NCH];
  logic [AMP_W-1:0]   r_s1_amp  [NCH];
  logic               r_s1_en   [NCH];
  logic [DAC_W-1:0]   r_s2_w    [NCH];
  logic [AMP_W-1:0]   r_s2_amp  [NCH];
  logic               r_s2_en   [NCH];
  logic               r_busy;
  logic [2:0]         r_wr_pipe;

  logic [PHASE_W-1:0] w_phase   [NCH];
  logic [DAC_W-1:0]   w_wave    [NCH];
  logic [PROD_W-1:0]  w_prod    [NCH];
  logic [DAC_W-1:0]   w_scaled  [NCH];
  logic               w_accept;
  logic               w_apply;
  logic               w_clear;

  assign cmd_ready = ~r_busy;
  assign w_accept  = cmd_valid & cmd_ready;
  assign w_apply   = w_accept & (cmd_reg == REG_APPLY);
  assign w_clear   = w_apply & cmd_data[0];
  assign dac_wr    = r_wr_pipe[2];

  // Command decode. Channel indices >= NCH match no loop iteration and are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      for (int unsigned n = 0; n < NCH; n++) begin
        r_sh_ftw[n]  <= '0;
        r_sh_poff[n] <= '0;
        r_sh_amp[n]  <= '0;
        r_sh_mode[n] <= '0;
        r_ftw[n]     <= '0;
        r_poff[n]    <= '0;
        r_amp[n]     <= '0;
        r_mode[n]    <= '0;
      end
    end else begin
      r_busy <= w_apply;
      for (int unsigned n = 0; n < NCH; n++) begin
        if (w_accept && cmd_ch == 3'(n)) begin
          case (cmd_reg)
            REG_FTW:  r_sh_ftw[n]  <= cmd_data;
            REG_POFF: r_sh_poff[n] <= cmd_data[PHASE_W-1:0];
            REG_AMP:  r_sh_amp[n]  <= cmd_data[AMP_W-1:0];
            REG_MODE: r_sh_mode[n] <= cmd_data[2:0];
            default:  ;
          endcase
        end
        if (w_apply) begin
          r_ftw[n]  <= r_sh_ftw[n];
          r_poff[n] <= r_sh_poff[n];
          r_amp[n]  <= r_sh_amp[n];
          r_mode[n] <= r_sh_mode[n];
        end
      end
    end
  end

  // S2 waveform and S3 amplitude scaling
  always_comb begin
    for (int unsigned n = 0; n < NCH; n++) begin
      w_phase[n] = r_acc[n][ACC_W-1 -: PHASE_W] + r_s1_poff[n];
      w_wave[n]  = '1;
      case (r_s1_wave[n])
        2'd0: w_wave[n] = {w_phase[n], {(DAC_W-PHASE_W){1'b0}}};
        2'd1: w_wave[n] = w_phase[n][PHASE_W-1]
                        ? ~{w_phase[n][PHASE_W-2:0], {(DAC_W-PHASE_W+1){1'b0}}}
                        :  {w_phase[n][PHASE_W-2:0], {(DAC_W-PHASE_W+1){1'b0}}};
        2'd2: w_wave[n] = w_phase[n][PHASE_W-1] ? '0 : '1;
        default: w_wave[n] = '1;
      endcase
      w_prod[n]   = PROD_W'(r_s2_w[n]) * PROD_W'({1'b0, r_s2_amp[n]} + (AMP_W+1)'(1));
      w_scaled[n] = r_s2_en[n] ? DAC_W'(w_prod[n] >> AMP_W) : '0;
    end
  end

  // The active config is staged alongside each accumulator value so that
  // an APPLY affects FTW, POFF, AMP and MODE on the same output sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_pipe <= '0;
      dac_data  <= '0;
      for (int unsigned n = 0; n < NCH; n++) begin
        r_acc[n]     <= '0;
        r_s1_poff[n] <= '0;
        r_s1_wave[n] <= '0;
        r_s1_amp[n]  <= '0;
        r_s1_en[n]   <= 1'b0;
        r_s2_w[n]    <= '0;
        r_s2_amp[n]  <= '0;
        r_s2_en[n]   <= 1'b0;
      end
    end else begin
      r_wr_pipe <= {r_wr_pipe[1:0], 1'b1};
      for (int unsigned n = 0; n < NCH; n++) begin
        if (w_clear) begin
          r_acc[n] <= '0;
        end else if (r_mode[n][2]) begin
          r_acc[n] <= r_acc[n] + r_ftw[n];
        end
        r_s1_poff[n] <= r_poff[n];
        r_s1_wave[n] <= r_mode[n][1:0];
        r_s1_amp[n]  <= r_amp[n];
        r_s1_en[n]   <= r_mode[n][2];
        r_s2_w[n]    <= w_wave[n];
        r_s2_amp[n]  <= r_s1_amp[n];
        r_s2_en[n]   <= r_s1_en[n];
        dac_data[n*DAC_W +: DAC_W] <= w_scaled[n];
      end
    end
  end

endmodule

// File: tb/tb_dds_multi_ch.sv
// tb_dds_multi_ch: scoreboard bench for dds_multi_ch. A reference model
// predicts each output sample from the command stream; a negedge monitor
// pops the predictions and compares them against dac_data.
module tb_dds_multi_ch;

  localparam int NCH     = 2;
  localparam int ACC_W   = 32;
  localparam int PHASE_W = 10;
  localparam int DAC_W   = 14;
  localparam int AMP_W   = 8;
  localparam int FULL    = (1 << DAC_W) - 1;

  logic                 clk       = 1'b0;
  logic                 rst_n     = 1'b1;
  logic                 cmd_valid = 1'b0;
  logic [2:0]           cmd_ch    = '0;
  logic [2:0]           cmd_reg   = '0;
  logic [ACC_W-1:0]     cmd_data  = '0;
  logic                 cmd_ready;
  logic [NCH*DAC_W-1:0] dac_data;
  logic                 dac_wr;

  int checks   = 0;
  int failures = 0;

  dds_multi_ch #(
    .NCH(NCH), .ACC_W(ACC_W), .PHASE_W(PHASE_W), .DAC_W(DAC_W), .AMP_W(AMP_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ch(cmd_ch), .cmd_reg(cmd_reg), .cmd_data(cmd_data),
    .dac_data(dac_data), .dac_wr(dac_wr)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [ACC_W-1:0] m_sh_ftw [NCH];
  logic [ACC_W-1:0] m_ftw    [NCH];
  logic [ACC_W-1:0] m_acc    [NCH];
  int m_sh_poff [NCH];
  int m_sh_amp  [NCH];
  int m_sh_mode [NCH];
  int m_poff    [NCH];
  int m_amp     [NCH];
  int m_mode    [NCH];
  bit m_busy;
  int ecount;

  typedef struct {
    int                   tgt;
    logic [NCH*DAC_W-1:0] data;
  } exp_t;
  exp_t sb[$];

  function automatic int ref_wave(input logic [ACC_W-1:0] acc, input int poff,
                                  input int mode, input int amp);
    int p, w, half, step;
    half = 1 << (PHASE_W - 1);
    step = 1 << (DAC_W - PHASE_W + 1);
    p = (int'(acc >> (ACC_W - PHASE_W)) + poff) % (1 << PHASE_W);
    if ((mode & 4) == 0) return 0;
    case (mode & 3)
      0:       w = p * (1 << (DAC_W - PHASE_W));
      1:       w = (p < half) ? p * step : FULL - (p - half) * step;
      2:       w = (p < half) ? FULL : 0;
      default: w = FULL;
    endcase
    return (w * (amp + 1)) >> AMP_W;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < NCH; n++) begin
        m_sh_ftw[n] = '0; m_ftw[n] = '0; m_acc[n] = '0;
        m_sh_poff[n] = 0; m_sh_amp[n] = 0; m_sh_mode[n] = 0;
        m_poff[n] = 0; m_amp[n] = 0; m_mode[n] = 0;
      end
      m_busy = 1'b0;
      ecount = 0;
      sb.delete();
    end else begin
      bit   take, apply, clr;
      exp_t e;
      take  = cmd_valid && !m_busy;
      apply = take && (cmd_reg == 3'd4);
      clr   = apply && cmd_data[0];
      ecount++;
      // sample seen two edges from now: this edge's accumulator with the config in force before it
      e.tgt  = ecount + 2;
      e.data = '0;
      for (int n = 0; n < NCH; n++) begin
        if (clr) m_acc[n] = '0;
        else if ((m_mode[n] & 4) != 0) m_acc[n] = m_acc[n] + m_ftw[n];
        e.data[n*DAC_W +: DAC_W] = DAC_W'(ref_wave(m_acc[n], m_poff[n], m_mode[n], m_amp[n]));
      end
      sb.push_back(e);
      if (take && cmd_reg < 3'd4 && int'(cmd_ch) < NCH) begin
        case (cmd_reg)
          3'd0:    m_sh_ftw[cmd_ch]  = cmd_data;
          3'd1:    m_sh_poff[cmd_ch] = int'(cmd_data % (1 << PHASE_W));
          3'd2:    m_sh_amp[cmd_ch]  = int'(cmd_data % (1 << AMP_W));
          default: m_sh_mode[cmd_ch] = int'(cmd_data % 8);
        endcase
      end
      if (apply) begin
        for (int n = 0; n < NCH; n++) begin
          m_ftw[n] = m_sh_ftw[n]; m_poff[n] = m_sh_poff[n];
          m_amp[n] = m_sh_amp[n]; m_mode[n] = m_sh_mode[n];
        end
      end
      m_busy = apply;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      exp_t e;
      checks++;
      if (cmd_ready !== !m_busy) begin
        failures++;
        $display("FAIL cmd_ready t=%0t got=%b exp=%b", $time, cmd_ready, !m_busy);
      end
      checks++;
      if (dac_wr !== (ecount >= 3)) begin
        failures++;
        $display("FAIL dac_wr t=%0t got=%b exp=%b", $time, dac_wr, (ecount >= 3));
      end
      if (dac_wr === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL sb_empty t=%0t got=%h exp=<prediction>", $time, dac_data);
        end else begin
          e = sb.pop_front();
          if (e.tgt != ecount || dac_data !== e.data) begin
            failures++;
            $display("FAIL dac_data t=%0t edge=%0d got=%h exp=%h (pred edge %0d)",
                     $time, ecount, dac_data, e.data, e.tgt);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [2:0] ch, input logic [2:0] rg,
                      input logic [ACC_W-1:0] d, output int stalls);
    bit ok;
    ok = 1'b0;
    stalls = 0;
    cmd_valid = 1'b1; cmd_ch = ch; cmd_reg = rg; cmd_data = d;
    for (int k = 0; k < 8 && !ok; k++) begin
      @(negedge clk);
      ok = cmd_ready;
      @(posedge clk); #1;
      if (!ok) stalls++;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL send_timeout ch=%0d reg=%0d got=not_accepted exp=accepted", ch, rg);
    end
    cmd_valid = 1'b0;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  initial begin
    int st;
    logic [2:0] rch, rrg;
    int r;

    // reset state
    #1 rst_n = 1'b0;
    #2;
    chk("rst_dac_data", 64'(dac_data), 64'd0);
    chk("rst_dac_wr", 64'(dac_wr), 64'd0);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    #19 rst_n = 1'b1;
    @(posedge clk); #1;
    idle(5);

    // ch0 saw, unity gain
    send(3'd0, 3'd0, 32'h0040_0000, st);
    send(3'd0, 3'd2, 32'd255, st);
    send(3'd0, 3'd3, 32'd4, st);
    send(3'd0, 3'd4, 32'd1, st);
    idle(1100);

    // half gain, then phase offset with no accumulator clear
    send(3'd0, 3'd2, 32'd127, st);
    send(3'd0, 3'd4, 32'd1, st);
    idle(100);
    send(3'd0, 3'd1, 32'd512, st);
    send(3'd0, 3'd4, 32'd0, st);
    idle(60);

    // ch1 square at Nyquist; shadow-only FTW write must not change output
    send(3'd1, 3'd0, 32'h8000_0000, st);
    send(3'd1, 3'd3, 32'd6, st);
    send(3'd1, 3'd2, 32'd255, st);
    send(3'd1, 3'd4, 32'd1, st);
    idle(20);
    send(3'd1, 3'd0, 32'h4000_0000, st);
    idle(20);

    // handshake: command right behind APPLY stalls exactly one cycle
    send(3'd0, 3'd4, 32'd0, st);
    chk("apply_no_stall", 64'(st), 64'd0);
    send(3'd0, 3'd3, 32'd5, st);
    chk("b2b_stall", 64'(st), 64'd1);
    send(3'd5, 3'd0, $urandom, st);
    send(3'd5, 3'd3, 32'd7, st);
    send(3'd0, 3'd6, $urandom, st);
    send(3'd0, 3'd4, 32'd0, st);
    idle(30);

    // randomized command traffic
    repeat (150) begin
      rch = 3'($urandom_range(0, 7));
      r   = $urandom_range(0, 9);
      rrg = (r >= 8) ? 3'd4 : 3'(r);
      send(rch, rrg, $urandom, st);
      idle($urandom_range(0, 6));
    end

    // async reset mid-stream with a non-zero output in flight
    send(3'd0, 3'd2, 32'd255, st);
    send(3'd0, 3'd3, 32'd7, st);
    send(3'd0, 3'd4, 32'd0, st);
    idle(5);
    chk("pre_reset_nonzero", 64'(dac_data[DAC_W-1:0] != '0), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_dac_data", 64'(dac_data), 64'd0);
    chk("async_rst_dac_wr", 64'(dac_wr), 64'd0);
    chk("async_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    idle(20);
    send(3'd0, 3'd0, 32'h0030_0000, st);
    send(3'd0, 3'd3, 32'd5, st);
    send(3'd0, 3'd2, 32'd200, st);
    send(3'd0, 3'd4, 32'd1, st);
    idle(400);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dds_multi_ch.md
Name: dds_multi_ch

Overview:
Parametrised multi-channel DDS waveform core, the successor to the fixed two-channel signal generator. Each of NCH channels has its own frequency tuning word, phase offset, amplitude and waveform mode. Configuration arrives as channel-addressed register writes over a valid/ready command port from the USB command decoder. Writes land in shadow registers and take effect on all channels together on an APPLY command. Outputs are unsigned DAC codes, packed into one bus with a write strobe.

Parameters:
NCH, 2, number of channels (1..8)
ACC_W, 32, phase accumulator / tuning word width
PHASE_W, 10, truncated phase width used for waveform generation
DAC_W, 14, DAC code width; must satisfy DAC_W >= PHASE_W+1
AMP_W, 8, amplitude register width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when valid&ready
cmd_ch  in  3  target channel index
cmd_reg  in  3  0=FTW 1=POFF 2=AMP 3=MODE 4=APPLY
cmd_data  in  ACC_W  write data (LSB-aligned)
dac_data  out  NCH*DAC_W  channel n at bits [n*DAC_W +: DAC_W]
dac_wr  out  1  high when dac_data is valid

Behaviour:
- Reset is asynchronous on rst_n low. It clears every shadow register, active register, accumulator and pipeline stage, and clears dac_data and dac_wr to 0. cmd_ready is 1 while in reset and after release.
- Per-channel shadow/active registers:
  - FTW: ACC_W bits.
  - POFF: PHASE_W bits, taken from cmd_data[PHASE_W-1:0].
  - AMP: AMP_W bits.
  - MODE: 3 bits, from cmd_data[2:0]. Bits [1:0] select the waveform: 0 saw, 1 triangle, 2 square, 3 DC. Bit [2] is enable.
- Command write (reg 0-3): the shadow register is written on the valid&ready cycle. Active registers are unchanged.
- Command with cmd_ch >= NCH: accepted and ignored. Unknown reg 5-7: accepted and ignored.
- APPLY (reg 4): on the accepting cycle, all channels copy shadow to active together. cmd_ch is ignored.
  - If cmd_data[0]=1, every accumulator is cleared to 0 on that same edge.
  - cmd_ready drops to 0 for exactly the one following cycle, then returns to 1.
- Pipeline, per channel, three register stages:
  - S1: if the active enable is set, acc <= acc + FTW (mod 2^ACC_W). If enable is clear, acc holds.
  - S2: p = acc[ACC_W-1 -: PHASE_W] + POFF (mod 2^PHASE_W). The waveform code w (unsigned, DAC_W bits) is:
    - saw: w = p << (DAC_W-PHASE_W)
    - triangle: if p MSB=0, w = p[PHASE_W-2:0] << (DAC_W-PHASE_W+1); else w = bitwise inverse of that value, within DAC_W bits
    - square: w = all-ones if p MSB=0, else 0
    - DC: w = all-ones
  - S3: out = (w * (AMP+1)) >> AMP_W, truncated to DAC_W. AMP = 2^AMP_W-1 gives unity gain.
- A disabled channel outputs 0 at S3, regardless of mode.
- Latency:
  - An accumulator value appears on dac_data 2 cycles after it is registered.
  - APPLY takes effect on dac_data 3 cycles after the accepting edge.
- dac_wr goes high on the 3rd rising edge after rst_n is released and stays high. It is cleared only by reset.
- Simultaneous events: APPLY with clear on the same edge as an accumulate step means the clear wins, so acc = 0.
- A reset in mid-operation discards all configuration. The channel must be rewritten and re-APPLYed.

Test Plan:
(defaults throughout)
1. Reset → all dac_data=0, dac_wr=0, cmd_ready=1. Three cycles after release → dac_wr=1 and dac_data still 0 (channels disabled).
2. ch0: FTW=2^22, AMP=255, MODE=4 (saw, enabled), then APPLY with clear → ch0 output steps 0,16,32,…,16368,0, repeating every 1024 cycles. ch1 stays 0.
3. Same setup with AMP=127 → ch0 sequence 0,8,16,…,8184. Then POFF=512 + APPLY(no clear) → output jumps by 4096 three cycles after the APPLY edge.
4. ch1: FTW=2^31, MODE=6 (square), AMP=255, APPLY with clear → ch1 alternates 16383,0 every cycle. Writing ch1 FTW=2^30 without APPLY → no change in output.
5. Command handshake: APPLY followed by back-to-back cmd_valid → cmd_ready=0 for exactly one cycle. A write to cmd_ch=5 is accepted with no effect on any channel.
6. Pull rst_n low mid-stream, asynchronously between edges → dac_data and dac_wr go to 0 immediately. After release, outputs stay 0 until the channel is reconfigured and APPLYed.
